bus_if: RTL and testbench

Bus master interface unit between a CPU pipeline memory port and one master slot (m0..m3) of the shared 4-master/8-slave bus. It takes a single-word CPU access and runs the full bus handshake: request, wait for grant, one-cycle address strobe, wait for slave ready. It returns read data and stalls the CPU until completion. A watchdog aborts accesses to slaves that never answer.

---
 rtl/bus_pkg.sv | 19 +
 rtl/bus_if_if.sv | 24 ++
 rtl/bus_if.sv | 94 +++++++++
 tb/tb_bus_if.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared constants, widths and FSM state encoding for the bus master interface unit.
package bus_pkg;

  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int WORD_ADDR_W = 30;
  localparam int WORD_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACCESS = 2'd2,
    WAIT   = 2'd3
  } state_t;

endpackage

// File: rtl/bus_if_if.sv
// Master-slot bus signals between one bus_if unit and the shared arbiter/mux fabric.
interface bus_if_if;
  import bus_pkg::*;

  logic                   bus_req_;
  logic                   bus_grnt_;
  logic [WORD_ADDR_W-1:0] bus_addr;
  logic                   bus_as_;
  logic                   bus_rw;
  logic [WORD_DATA_W-1:0] bus_wr_data;
  logic [WORD_DATA_W-1:0] bus_rd_data;
  logic                   bus_rdy_;

  modport master (
    output bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
    input  bus_grnt_, bus_rd_data, bus_rdy_
  );

  modport slave (
    input  bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data,
    output bus_grnt_, bus_rd_data, bus_rdy_
  );

endinterface

// File: rtl/bus_if.sv
// Bus master interface unit: runs request/grant/strobe/ready for one CPU word access,
// returns read data, stalls the CPU, and aborts via watchdog when no slave answers.
module bus_if
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_as_,
  input  logic                   cpu_rw,
  input  logic [WORD_ADDR_W-1:0] cpu_addr,
  input  logic [WORD_DATA_W-1:0] cpu_wr_data,
  input  logic                   cpu_stall,
  input  logic                   cpu_flush,
  output logic [WORD_DATA_W-1:0] cpu_rd_data,
  output logic                   cpu_busy,
  output logic                   cpu_err,
  bus_if_if.master               bus
);

  state_t      state, next_state;
  logic [15:0] cnt;
  logic        launch;
  logic        granted;
  logic        done;
  logic        timeout;

  assign launch  = (state == IDLE) && (cpu_as_ == ENABLE_) && !cpu_flush;
  assign granted = (state == REQ) && (bus.bus_grnt_ == ENABLE_);
  assign done    = (state == ACCESS) && (bus.bus_rdy_ == ENABLE_);
  assign timeout = (state == ACCESS) && (bus.bus_rdy_ == DISABLE_) &&
                   (cnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (launch)  next_state = REQ;
      REQ:     if (granted) next_state = ACCESS;
      ACCESS:  if (done || timeout) next_state = cpu_stall ? WAIT : IDLE;
      WAIT:    if (!cpu_stall) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    cpu_busy = 1'b0;
    case (state)
      IDLE:    cpu_busy = launch;
      REQ:     cpu_busy = 1'b1;
      ACCESS:  cpu_busy = (bus.bus_rdy_ == DISABLE_) && !timeout;
      default: cpu_busy = 1'b0;
    endcase
  end

  // Registered bus/CPU outputs and the watchdog counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.bus_req_    <= DISABLE_;
      bus.bus_as_     <= DISABLE_;
      bus.bus_rw      <= READ;
      bus.bus_addr    <= '0;
      bus.bus_wr_data <= '0;
      cpu_rd_data     <= '0;
      cpu_err         <= 1'b0;
      cnt             <= '0;
    end else begin
      cpu_err     <= timeout;
      bus.bus_as_ <= granted ? ENABLE_ : DISABLE_;
      if (launch) begin
        bus.bus_addr    <= cpu_addr;
        bus.bus_rw      <= cpu_rw;
        bus.bus_wr_data <= cpu_wr_data;
        bus.bus_req_    <= ENABLE_;
      end
      if (granted) cnt <= '0;
      if (done) begin
        if (bus.bus_rw == READ) cpu_rd_data <= bus.bus_rd_data;
        bus.bus_req_ <= DISABLE_;
      end else if (timeout) begin
        cpu_rd_data  <= '0;
        bus.bus_req_ <= DISABLE_;
      end else if (state == ACCESS) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_bus_if.sv
// Directed self-checking bench for bus_if with a short watchdog (TIMEOUT_CYC=4).
module tb_bus_if;
  import bus_pkg::*;

  logic        clk;
  logic        reset;
  logic        cpu_as_;
  logic        cpu_rw;
  logic [29:0] cpu_addr;
  logic [31:0] cpu_wr_data;
  logic        cpu_stall;
  logic        cpu_flush;
  logic [31:0] cpu_rd_data;
  logic        cpu_busy;
  logic        cpu_err;

  int compared;
  int mismatched;

  bus_if_if bif();

  bus_if #(.TIMEOUT_CYC(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_as_     (cpu_as_),
    .cpu_rw      (cpu_rw),
    .cpu_addr    (cpu_addr),
    .cpu_wr_data (cpu_wr_data),
    .cpu_stall   (cpu_stall),
    .cpu_flush   (cpu_flush),
    .cpu_rd_data (cpu_rd_data),
    .cpu_busy    (cpu_busy),
    .cpu_err     (cpu_err),
    .bus         (bif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; cpu_as_ = 1'b1; cpu_rw = 1'b1; cpu_addr = '0; cpu_wr_data = '0;
    cpu_stall = 1'b0; cpu_flush = 1'b0;
    bif.bus_grnt_ = 1'b1; bif.bus_rdy_ = 1'b1; bif.bus_rd_data = '0;
    #12;
    compared++; if (bif.bus_req_ !== 1'b1) begin mismatched++; $display("FAIL rst_req got=%b exp=1", bif.bus_req_); end
    compared++; if (bif.bus_as_ !== 1'b1) begin mismatched++; $display("FAIL rst_as got=%b exp=1", bif.bus_as_); end
    compared++; if (bif.bus_rw !== 1'b1) begin mismatched++; $display("FAIL rst_rw got=%b exp=1", bif.bus_rw); end
    compared++; if (bif.bus_addr !== 30'h0) begin mismatched++; $display("FAIL rst_addr got=%h exp=0", bif.bus_addr); end
    compared++; if (bif.bus_wr_data !== 32'h0) begin mismatched++; $display("FAIL rst_wdata got=%h exp=0", bif.bus_wr_data); end
    compared++; if (cpu_rd_data !== 32'h0) begin mismatched++; $display("FAIL rst_rdata got=%h exp=0", cpu_rd_data); end
    compared++; if (cpu_err !== 1'b0) begin mismatched++; $display("FAIL rst_err got=%b exp=0", cpu_err); end
    compared++; if (cpu_busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy got=%b exp=0", cpu_busy); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_read();
    cpu_as_ = 1'b0; cpu_rw = 1'b1; cpu_addr = 30'h100;
    #1;
    compared++; if (cpu_busy !== 1'b1) begin mismatched++; $display("FAIL rd_busy_idle got=%b exp=1", cpu_busy); end
    tick();
    compared++; if (bif.bus_req_ !== 1'b0) begin mismatched++; $display("FAIL rd_req_e1 got=%b exp=0", bif.bus_req_); end
    compared++; if (bif.bus_as_ !== 1'b1) begin mismatched++; $display("FAIL rd_as_e1 got=%b exp=1", bif.bus_as_); end
    compared++; if (bif.bus_addr !== 30'h100) begin mismatched++; $display("FAIL rd_addr got=%h exp=100", bif.bus_addr); end
    compared++; if (bif.bus_rw !== 1'b1) begin mismatched++; $display("FAIL rd_rw got=%b exp=1", bif.bus_rw); end
    bif.bus_grnt_ = 1'b0;
    tick();
    compared++; if (bif.bus_as_ !== 1'b0) begin mismatched++; $display("FAIL rd_as_e2 got=%b exp=0", bif.bus_as_); end
    compared++; if (bif.bus_req_ !== 1'b0) begin mismatched++; $display("FAIL rd_req_e2 got=%b exp=0", bif.bus_req_); end
    compared++; if (cpu_busy !== 1'b1) begin mismatched++; $display("FAIL rd_busy_acc_nrdy got=%b exp=1", cpu_busy); end
    bif.bus_rdy_ = 1'b0; bif.bus_rd_data = 32'hDEADBEEF;
    #1;
    compared++; if (cpu_busy !== 1'b0) begin mismatched++; $display("FAIL rd_busy_acc_rdy got=%b exp=0", cpu_busy); end
    tick();
    compared++; if (cpu_rd_data !== 32'hDEADBEEF) begin mismatched++; $display("FAIL rd_data got=%h exp=deadbeef", cpu_rd_data); end
    compared++; if (bif.bus_req_ !== 1'b1) begin mismatched++; $display("FAIL rd_req_e3 got=%b exp=1", bif.bus_req_); end
    compared++; if (bif.bus_as_ !== 1'b1) begin mismatched++; $display("FAIL rd_as_e3 got=%b exp=1", bif.bus_as_); end
    cpu_as_ = 1'b1; bif.bus_rdy_ = 1'b1; bif.bus_grnt_ = 1'b1; bif.bus_rd_data = 32'h0;
    #1;
    compared++; if (cpu_busy !== 1'b0) begin mismatched++; $display("FAIL rd_busy_after got=%b exp=0", cpu_busy); end
    tick();
  endtask

  task automatic test_write();
    cpu_as_ = 1'b0; cpu_rw = 1'b0; cpu_addr = 30'h3FF; cpu_wr_data = 32'h12345678;
    tick();
    compared++; if (bif.bus_rw !== 1'b0) begin mismatched++; $display("FAIL wr_rw got=%b exp=0", bif.bus_rw); end
    compared++; if (bif.bus_wr_data !== 32'h12345678) begin mismatched++; $display("FAIL wr_wdata got=%h exp=12345678", bif.bus_wr_data); end
    tick();
    tick();
    compared++; if (bif.bus_req_ !== 1'b0) begin mismatched++; $display("FAIL wr_req_wait got=%b exp=0", bif.bus_req_); end
    compared++; if (bif.bus_as_ !== 1'b1) begin mismatched++; $display("FAIL wr_as_wait got=%b exp=1", bif.bus_as_); end
    compared++; if (cpu_busy !== 1'b1) begin mismatched++; $display("FAIL wr_busy_req got=%b exp=1", cpu_busy); end
    bif.bus_grnt_ = 1'b0;
    cpu_wr_data = 32'hFFFFFFFF;
    tick();
    compared++; if (bif.bus_as_ !== 1'b0) begin mismatched++; $display("FAIL wr_as_c1 got=%b exp=0", bif.bus_as_); end
    tick();
    compared++; if (bif.bus_as_ !== 1'b1) begin mismatched++; $display("FAIL wr_as_c2 got=%b exp=1", bif.bus_as_); end
    compared++; if (bif.bus_wr_data !== 32'h12345678) begin mismatched++; $display("FAIL wr_wdata_c2 got=%h exp=12345678", bif.bus_wr_data); end
    compared++; if (cpu_busy !== 1'b1) begin mismatched++; $display("FAIL wr_busy_c2 got=%b exp=1", cpu_busy); end
    tick();
    compared++; if (bif.bus_addr !== 30'h3FF) begin mismatched++; $display("FAIL wr_addr_c3 got=%h exp=3ff", bif.bus_addr); end
    bif.bus_rdy_ = 1'b0; bif.bus_rd_data = 32'h55555555;
    #1;
    compared++; if (cpu_busy !== 1'b0) begin mismatched++; $display("FAIL wr_busy_c3 got=%b exp=0", cpu_busy); end
    tick();
    compared++; if (cpu_rd_data !== 32'hDEADBEEF) begin mismatched++; $display("FAIL wr_rdata_kept got=%h exp=deadbeef", cpu_rd_data); end
    compared++; if (cpu_err !== 1'b0) begin mismatched++; $display("FAIL wr_err got=%b exp=0", cpu_err); end
    compared++; if (bif.bus_req_ !== 1'b1) begin mismatched++; $display("FAIL wr_req_done got=%b exp=1", bif.bus_req_); end
    cpu_as_ = 1'b1; bif.bus_rdy_ = 1'b1; bif.bus_grnt_ = 1'b1;
    tick();
  endtask

  task automatic test_timeout();
    cpu_as_ = 1'b0; cpu_rw = 1'b1; cpu_addr = 30'h5;
    tick();
    bif.bus_grnt_ = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      compared++; if (cpu_busy !== 1'b1) begin mismatched++; $display("FAIL to_busy_c%0d got=%b exp=1", i + 1, cpu_busy); end
      tick();
    end
    compared++; if (cpu_busy !== 1'b0) begin mismatched++; $display("FAIL to_busy_c4 got=%b exp=0", cpu_busy); end
    compared++; if (cpu_err !== 1'b0) begin mismatched++; $display("FAIL to_err_early got=%b exp=0", cpu_err); end
    tick();
    compared++; if (cpu_err !== 1'b1) begin mismatched++; $display("FAIL to_err got=%b exp=1", cpu_err); end
    compared++; if (cpu_rd_data !== 32'h0) begin mismatched++; $display("FAIL to_rdata got=%h exp=0", cpu_rd_data); end
    compared++; if (bif.bus_req_ !== 1'b1) begin mismatched++; $display("FAIL to_req got=%b exp=1", bif.bus_req_); end
    cpu_as_ = 1'b1; bif.bus_grnt_ = 1'b1;
    tick();
    compared++; if (cpu_err !== 1'b0) begin mismatched++; $display("FAIL to_err_pulse got=%b exp=0", cpu_err); end
    compared++; if (bif.bus_req_ !== 1'b1) begin mismatched++; $display("FAIL to_idle_req got=%b exp=1", bif.bus_req_); end
  endtask

  task automatic test_stall();
    cpu_as_ = 1'b0; cpu_rw = 1'b1; cpu_addr = 30'h7;
    tick();
    bif.bus_grnt_ = 1'b0;
    tick();
    bif.bus_rdy_ = 1'b0; bif.bus_rd_data = 32'hA5A5A5A5; cpu_stall = 1'b1;
    tick();
    bif.bus_rdy_ = 1'b1; bif.bus_grnt_ = 1'b1; bif.bus_rd_data = 32'h0;
    cpu_addr = 30'h8;
    #1;
    compared++; if (cpu_rd_data !== 32'hA5A5A5A5) begin mismatched++; $display("FAIL st_rdata got=%h exp=a5a5a5a5", cpu_rd_data); end
    compared++; if (cpu_busy !== 1'b0) begin mismatched++; $display("FAIL st_busy got=%b exp=0", cpu_busy); end
    tick();
    tick();
    compared++; if (bif.bus_req_ !== 1'b1) begin mismatched++; $display("FAIL st_no_req got=%b exp=1", bif.bus_req_); end
    compared++; if (cpu_busy !== 1'b0) begin mismatched++; $display("FAIL st_busy_hold got=%b exp=0", cpu_busy); end
    compared++; if (cpu_rd_data !== 32'hA5A5A5A5) begin mismatched++; $display("FAIL st_rdata_hold got=%h exp=a5a5a5a5", cpu_rd_data); end
    cpu_stall = 1'b0;
    tick();
    compared++; if (bif.bus_req_ !== 1'b1) begin mismatched++; $display("FAIL st_idle_req got=%b exp=1", bif.bus_req_); end
    compared++; if (cpu_busy !== 1'b1) begin mismatched++; $display("FAIL st_idle_busy got=%b exp=1", cpu_busy); end
    tick();
    compared++; if (bif.bus_req_ !== 1'b0) begin mismatched++; $display("FAIL st_new_req got=%b exp=0", bif.bus_req_); end
    compared++; if (bif.bus_addr !== 30'h8) begin mismatched++; $display("FAIL st_new_addr got=%h exp=8", bif.bus_addr); end
    bif.bus_grnt_ = 1'b0;
    tick();
    bif.bus_rdy_ = 1'b0; bif.bus_rd_data = 32'h0BADF00D;
    tick();
    compared++; if (cpu_rd_data !== 32'h0BADF00D) begin mismatched++; $display("FAIL st_new_rdata got=%h exp=0badf00d", cpu_rd_data); end
    cpu_as_ = 1'b1; bif.bus_rdy_ = 1'b1; bif.bus_grnt_ = 1'b1;
    tick();
  endtask

  task automatic test_flush();
    cpu_as_ = 1'b0; cpu_rw = 1'b1; cpu_addr = 30'h9; cpu_flush = 1'b1;
    #1;
    compared++; if (cpu_busy !== 1'b0) begin mismatched++; $display("FAIL fl_busy got=%b exp=0", cpu_busy); end
    tick();
    tick();
    compared++; if (bif.bus_req_ !== 1'b1) begin mismatched++; $display("FAIL fl_no_req got=%b exp=1", bif.bus_req_); end
    cpu_flush = 1'b0;
    tick();
    compared++; if (bif.bus_req_ !== 1'b0) begin mismatched++; $display("FAIL fl_req got=%b exp=0", bif.bus_req_); end
    bif.bus_grnt_ = 1'b0;
    tick();
    cpu_flush = 1'b1;
    tick();
    compared++; if (bif.bus_req_ !== 1'b0) begin mismatched++; $display("FAIL fl_acc_req got=%b exp=0", bif.bus_req_); end
    bif.bus_rdy_ = 1'b0; bif.bus_rd_data = 32'hCAFEF00D;
    tick();
    compared++; if (cpu_rd_data !== 32'hCAFEF00D) begin mismatched++; $display("FAIL fl_rdata got=%h exp=cafef00d", cpu_rd_data); end
    cpu_as_ = 1'b1; cpu_flush = 1'b0; bif.bus_rdy_ = 1'b1; bif.bus_grnt_ = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    cpu_as_ = 1'b0; cpu_rw = 1'b1; cpu_addr = 30'h20;
    tick();
    bif.bus_grnt_ = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    cpu_as_ = 1'b1; bif.bus_grnt_ = 1'b1;
    #1;
    compared++; if (bif.bus_req_ !== 1'b1) begin mismatched++; $display("FAIL rm_req got=%b exp=1", bif.bus_req_); end
    compared++; if (bif.bus_as_ !== 1'b1) begin mismatched++; $display("FAIL rm_as got=%b exp=1", bif.bus_as_); end
    compared++; if (bif.bus_addr !== 30'h0) begin mismatched++; $display("FAIL rm_addr got=%h exp=0", bif.bus_addr); end
    compared++; if (cpu_busy !== 1'b0) begin mismatched++; $display("FAIL rm_busy got=%b exp=0", cpu_busy); end
    tick();
    reset = 1'b1;
    tick();
    cpu_as_ = 1'b0; cpu_addr = 30'h2A;
    tick();
    compared++; if (bif.bus_addr !== 30'h2A) begin mismatched++; $display("FAIL rm_new_addr got=%h exp=2a", bif.bus_addr); end
    bif.bus_grnt_ = 1'b0;
    tick();
    compared++; if (bif.bus_as_ !== 1'b0) begin mismatched++; $display("FAIL rm_new_as got=%b exp=0", bif.bus_as_); end
    bif.bus_rdy_ = 1'b0; bif.bus_rd_data = 32'h13572468;
    tick();
    compared++; if (cpu_rd_data !== 32'h13572468) begin mismatched++; $display("FAIL rm_new_rdata got=%h exp=13572468", cpu_rd_data); end
    cpu_as_ = 1'b1; bif.bus_rdy_ = 1'b1; bif.bus_grnt_ = 1'b1;
    tick();
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
